// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: replays a fixed, cycle-exact press schedule
// and can inject one timeout or one wrong button at a chosen (rodada, jogada).
module jogador_automatico #(
  parameter int NUM_RODADAS = 16,
  parameter int T_JOGAR     = 5,
  parameter int T_INICIO    = 10,
  parameter int T_PRESS     = 5,
  parameter int T_GAP       = 5,
  parameter int T_ATRASO    = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] inj_tipo,
  input  logic [3:0] inj_rodada,
  input  logic [3:0] inj_jogada,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim,
  output logic       ganhou_vis,
  output logic       perdeu_vis,
  output logic [3:0] db_rodada,
  output logic [3:0] db_jogada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO    = 4'h0,
    JOGAR     = 4'h1,
    ESPERA    = 4'h2,
    ATRASO    = 4'h3,
    PRESSIONA = 4'h4,
    SOLTA     = 4'h5,
    PROXIMA   = 4'h6,
    FIM       = 4'hF
  } estado_t;

  localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS - 1);

  estado_t    estado_q, estado_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] rodada_q, rodada_d, jogada_q, jogada_d;
  logic [1:0] inj_tipo_q;
  logic [3:0] inj_rodada_q, inj_jogada_q;
  logic       inicia, encerra, ocupado_atual, indices_casam, troca;
  logic [1:0] botao_idx;
  logic [3:0] botoes_d;

  // Each timed state lasts T cycles: load T-1 on entry, leave when the timer is 0.
  function automatic logic [7:0] recarga(input estado_t e);
    case (e)
      JOGAR:     recarga = 8'(T_JOGAR - 1);
      ESPERA:    recarga = 8'(T_INICIO - 1);
      ATRASO:    recarga = 8'(T_ATRASO - 1);
      PRESSIONA: recarga = 8'(T_PRESS - 1);
      SOLTA:     recarga = 8'(T_GAP - 1);
      default:   recarga = 8'd0;
    endcase
  endfunction

  always_comb begin
    estado_d      = estado_q;
    timer_d       = timer_q;
    rodada_d      = rodada_q;
    jogada_d      = jogada_q;
    inicia        = 1'b0;
    encerra       = 1'b0;
    ocupado_atual = (estado_q != OCIOSO) && (estado_q != FIM);

    if (!ocupado_atual) begin
      if (iniciar) begin
        estado_d = JOGAR;
        rodada_d = 4'd0;
        jogada_d = 4'd0;
        inicia   = 1'b1;
      end
    end else if (pronto) begin
      estado_d = FIM;
      encerra  = 1'b1;
    end else if (estado_q == PROXIMA) begin
      if (jogada_q < rodada_q) begin
        jogada_d = jogada_q + 4'd1;
        estado_d = PRESSIONA;
      end else if (rodada_q == ULTIMA) begin
        estado_d = FIM;
      end else begin
        jogada_d = 4'd0;
        rodada_d = rodada_q + 4'd1;
        estado_d = PRESSIONA;
      end
    end else if (timer_q != 8'd0) begin
      timer_d = timer_q - 8'd1;
    end else begin
      case (estado_q)
        JOGAR:     estado_d = ESPERA;
        ESPERA:    estado_d = PRESSIONA;
        ATRASO:    estado_d = PRESSIONA;
        PRESSIONA: estado_d = SOLTA;
        SOLTA:     estado_d = PROXIMA;
        default:   estado_d = OCIOSO;
      endcase
    end

    // Match is evaluated against the indices of the press about to start.
    indices_casam = (rodada_d == inj_rodada_q) && (jogada_d == inj_jogada_q);
    if ((estado_d == PRESSIONA) && ((estado_q == ESPERA) || (estado_q == PROXIMA))
        && (inj_tipo_q == 2'b01) && indices_casam)
      estado_d = ATRASO;

    if (estado_d != estado_q)
      timer_d = recarga(estado_d);

    troca     = (inj_tipo_q == 2'b10) && indices_casam;
    botao_idx = jogada_d[1:0] + {1'b0, troca};
    botoes_d  = (estado_d == PRESSIONA) ? (4'b0001 << botao_idx) : 4'b0000;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      timer_q      <= 8'd0;
      rodada_q     <= 4'd0;
      jogada_q     <= 4'd0;
      inj_tipo_q   <= 2'b00;
      inj_rodada_q <= 4'd0;
      inj_jogada_q <= 4'd0;
      jogar        <= 1'b0;
      botoes       <= 4'b0000;
      ocupado      <= 1'b0;
      fim          <= 1'b0;
      ganhou_vis   <= 1'b0;
      perdeu_vis   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      rodada_q <= rodada_d;
      jogada_q <= jogada_d;
      if (inicia) begin
        inj_tipo_q   <= inj_tipo;
        inj_rodada_q <= inj_rodada;
        inj_jogada_q <= inj_jogada;
      end
      // Outputs come from the next state so they line up with db_estado.
      jogar   <= (estado_d == JOGAR);
      botoes  <= botoes_d;
      ocupado <= (estado_d != OCIOSO) && (estado_d != FIM);
      fim     <= (estado_d == FIM);
      if (inicia) begin
        ganhou_vis <= 1'b0;
        perdeu_vis <= 1'b0;
      end else if (encerra) begin
        ganhou_vis <= ganhou;
        perdeu_vis <= perdeu;
      end
    end
  end

  assign db_estado = estado_q;
  assign db_rodada = rodada_q;
  assign db_jogada = jogada_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: table of full-game scenarios checked press by press,
// plus directed sequences for early end, busy/reset handling and restart.
module tb_jogador_automatico;

  localparam int NR        = 16;
  localparam int N_PRESSES = NR * (NR + 1) / 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] inj_tipo = 2'b00;
  logic [3:0] inj_rodada = 4'd0;
  logic [3:0] inj_jogada = 4'd0;
  logic       pronto = 1'b0;
  logic       ganhou = 1'b0;
  logic       perdeu = 1'b0;
  logic       jogar;
  logic [3:0] botoes;
  logic       ocupado;
  logic       fim;
  logic       ganhou_vis;
  logic       perdeu_vis;
  logic [3:0] db_rodada;
  logic [3:0] db_jogada;
  logic [3:0] db_estado;

  jogador_automatico #(
    .NUM_RODADAS(NR), .T_JOGAR(5), .T_INICIO(10), .T_PRESS(5), .T_GAP(5), .T_ATRASO(6)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .inj_tipo(inj_tipo), .inj_rodada(inj_rodada), .inj_jogada(inj_jogada),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .jogar(jogar), .botoes(botoes), .ocupado(ocupado), .fim(fim),
    .ganhou_vis(ganhou_vis), .perdeu_vis(perdeu_vis),
    .db_rodada(db_rodada), .db_jogada(db_jogada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] tipo;
    logic [3:0] rod;
    logic [3:0] jog;
    int         exp_idx;
    logic [3:0] exp_val;
    int         exp_gap;
    int         exp_first;
  } scen_t;

  scen_t      tab[6];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; iniciar = 1'b0; pronto = 1'b0; ganhou = 1'b0; perdeu = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (edge 0 sampled iniciar).
  task automatic start_game();
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] est, input logic [3:0] rod, input int budget,
                            input string name);
    int c;
    c = 0;
    while (!(db_estado == est && db_rodada == rod) && c < budget) begin
      @(negedge clock);
      c++;
    end
    check(name, (db_estado == est && db_rodada == rod) ? 1 : 0, 1);
  endtask

  task automatic run_scenario(input int k, input scen_t s);
    logic [3:0] samp[$];
    logic       jsamp[$];
    int         p_start[$];
    int         p_len[$];
    logic [3:0] p_val[$];
    int         fim_cyc, j_first, j_last, j_cnt, p, r, j, len, gap;
    logic [3:0] ev;
    do_reset();
    inj_tipo = s.tipo; inj_rodada = s.rod; inj_jogada = s.jog;
    start_game();
    // Changing the inputs after the start must not affect this game.
    inj_tipo = 2'b00; inj_rodada = 4'd0; inj_jogada = 4'd0;
    fim_cyc = -1;
    for (int c = 1; c <= 3000; c++) begin
      if (fim) begin
        fim_cyc = c;
        break;
      end
      samp.push_back(botoes);
      jsamp.push_back(jogar);
      @(negedge clock);
    end
    j_first = -1; j_last = -1; j_cnt = 0;
    for (int i = 0; i < jsamp.size(); i++) begin
      if (jsamp[i]) begin
        if (j_first < 0) j_first = i + 1;
        j_last = i + 1;
        j_cnt++;
      end
    end
    check($sformatf("s%0d_jogar_first", k), j_first, 1);
    check($sformatf("s%0d_jogar_last", k), j_last, 5);
    check($sformatf("s%0d_jogar_count", k), j_cnt, 5);

    for (int i = 0; i < samp.size(); i++) begin
      if (samp[i] != 4'b0000 && (i == 0 || samp[i-1] == 4'b0000)) begin
        len = 0;
        while (i + len < samp.size() && samp[i+len] == samp[i]) len++;
        p_start.push_back(i + 1);
        p_val.push_back(samp[i]);
        p_len.push_back(len);
      end
    end

    exp_q.delete();
    p = 0;
    for (r = 0; r < NR; r++) begin
      for (j = 0; j <= r; j++) begin
        ev = 4'b0001 << (j % 4);
        exp_q.push_back((p == s.exp_idx) ? s.exp_val : ev);
        p++;
      end
    end

    check($sformatf("s%0d_n_presses", k), p_start.size(), N_PRESSES);
    if (p_start.size() > 0)
      check($sformatf("s%0d_first_press_cycle", k), p_start[0], s.exp_first);
    for (int q = 0; q < p_start.size() && exp_q.size() > 0; q++) begin
      check($sformatf("s%0d_press%0d_val", k, q), p_val[q], exp_q.pop_front());
      check($sformatf("s%0d_press%0d_len", k, q), p_len[q], 5);
      if (q > 0) begin
        gap = p_start[q] - (p_start[q-1] + p_len[q-1]);
        check($sformatf("s%0d_press%0d_gap", k, q), gap, (q == s.exp_idx) ? s.exp_gap : 6);
      end
    end
    if (p_start.size() > 0)
      check($sformatf("s%0d_fim_cycle", k), fim_cyc, p_start[p_start.size()-1] + 11);
    check($sformatf("s%0d_end_ocupado", k), ocupado, 0);
    check($sformatf("s%0d_end_ganhou_vis", k), ganhou_vis, 0);
    check($sformatf("s%0d_end_perdeu_vis", k), perdeu_vis, 0);
    check($sformatf("s%0d_end_estado", k), db_estado, 4'hF);
  endtask

  initial begin
    int nz;
    tab[0] = '{tipo: 2'b00, rod: 4'd0,  jog: 4'd0,  exp_idx: 0,   exp_val: 4'b0001, exp_gap: 0,  exp_first: 16};
    tab[1] = '{tipo: 2'b01, rod: 4'd3,  jog: 4'd1,  exp_idx: 7,   exp_val: 4'b0010, exp_gap: 12, exp_first: 16};
    tab[2] = '{tipo: 2'b10, rod: 4'd2,  jog: 4'd2,  exp_idx: 5,   exp_val: 4'b1000, exp_gap: 6,  exp_first: 16};
    tab[3] = '{tipo: 2'b11, rod: 4'd3,  jog: 4'd1,  exp_idx: 7,   exp_val: 4'b0010, exp_gap: 6,  exp_first: 16};
    tab[4] = '{tipo: 2'b01, rod: 4'd0,  jog: 4'd0,  exp_idx: 0,   exp_val: 4'b0001, exp_gap: 0,  exp_first: 22};
    tab[5] = '{tipo: 2'b10, rod: 4'd15, jog: 4'd15, exp_idx: 135, exp_val: 4'b0001, exp_gap: 6,  exp_first: 16};

    // Reset state
    do_reset();
    check("rst_jogar", jogar, 0);
    check("rst_botoes", botoes, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_fim", fim, 0);
    check("rst_vis", {ganhou_vis, perdeu_vis}, 0);
    check("rst_estado", db_estado, 0);
    check("rst_indices", {db_rodada, db_jogada}, 0);

    for (int k = 0; k < 6; k++) run_scenario(k, tab[k]);

    // Early end on loss during a press of rodada 3
    do_reset();
    start_game();
    wait_state(4'h4, 4'd3, 2000, "loss_reach_press_r3");
    pronto = 1'b1; perdeu = 1'b1;
    @(negedge clock);
    pronto = 1'b0; perdeu = 1'b0;
    check("loss_botoes", botoes, 0);
    check("loss_fim", fim, 1);
    check("loss_perdeu_vis", perdeu_vis, 1);
    check("loss_ganhou_vis", ganhou_vis, 0);
    check("loss_ocupado", ocupado, 0);
    nz = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (botoes != 4'b0000) nz++;
    end
    check("loss_no_more_presses", nz, 0);
    check("loss_fim_holds", fim, 1);

    // iniciar while busy is ignored, then reset mid-press
    do_reset();
    start_game();
    wait_state(4'h4, 4'd0, 100, "busy_reach_first_press");
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("busy_estado", db_estado, 4'h4);
    check("busy_jogar", jogar, 0);
    check("busy_botoes", botoes, 4'b0001);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_botoes", botoes, 0);
    check("midrst_ocupado", ocupado, 0);
    check("midrst_estado", db_estado, 0);
    repeat (3) @(negedge clock);
    check("midrst_stays_idle", db_estado, 0);

    // Win, pronto ignored in FIM, then restart
    do_reset();
    start_game();
    wait_state(4'h4, 4'd2, 1000, "win_reach_press_r2");
    pronto = 1'b1; ganhou = 1'b1;
    @(negedge clock);
    pronto = 1'b0; ganhou = 1'b0;
    check("win_ganhou_vis", ganhou_vis, 1);
    check("win_fim", fim, 1);
    pronto = 1'b1; perdeu = 1'b1;
    @(negedge clock);
    pronto = 1'b0; perdeu = 1'b0;
    check("fim_pronto_ignored_perdeu", perdeu_vis, 0);
    check("fim_pronto_ignored_ganhou", ganhou_vis, 1);
    start_game();
    check("restart_ganhou_vis", ganhou_vis, 0);
    check("restart_rodada", db_rodada, 0);
    check("restart_jogada", db_jogada, 0);
    check("restart_fim", fim, 0);
    check("restart_ocupado", ocupado, 1);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("restart_jogar_c%0d", c), jogar, (c <= 5) ? 1 : 0);
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
